// File: rtl/sdram_req_master_pkg.sv
// ---------------------------------------------------------------------------
// sdram_req_master_pkg
// Shared definitions for the SDRAM request master:
//   - FSM state encoding (3 bits)
//   - command FIFO entry layout {wr, addr, len}
//   - default request timeout
// ---------------------------------------------------------------------------
package sdram_req_master_pkg;

    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_IDLE      = 3'd1,
        S_REQ       = 3'd2,
        S_ACK       = 3'd3,
        S_DONE      = 3'd4
    } state_e;

    // Entry layout, LSB first: len, then addr, then the direction bit.
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned LEN_LSB  = 0;
    localparam int unsigned ADDR_LSB = LEN_LSB + LEN_W;

    localparam int unsigned DEF_TIMEOUT_CYC = 4096;

    function automatic int unsigned wr_bit(input int unsigned addr_w);
        return ADDR_LSB + addr_w;
    endfunction

    function automatic int unsigned entry_w(input int unsigned addr_w);
        return addr_w + LEN_W + 1;
    endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// ---------------------------------------------------------------------------
// sdram_req_fifo
// Synchronous command FIFO. DEPTH must be a power of 2 (>= 2); pointers wrap
// modulo DEPTH. Push while full is honoured only together with a pop.
// Ports:
//   clk_100m, rst_n  clock, asynchronous active-low reset
//   push, wdata      write strobe and data
//   pop              remove head entry (ignored when empty)
//   rdata            head entry (valid when !empty)
//   full, empty      occupancy flags
//   count            number of stored entries (clog2(DEPTH)+1 bits)
// ---------------------------------------------------------------------------
module sdram_req_fifo #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_100m,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk_100m) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_req_master.sv
// ---------------------------------------------------------------------------
// sdram_req_master
// Host-side requester for the SDRAM controller request/ack handshake.
// Host commands are queued; one at a time is presented to the controller with
// a registered request held until the matching ack rises, then the ack fall
// marks the end of the burst. A timeout aborts a stuck transaction.
// Optional feature macro: SDRAM_REQ_STATS_EN adds saturating completion and
// timeout counters (stat_rd_cnt, stat_wr_cnt, stat_to_cnt).
// Ports:
//   clk_100m, rst_n              clock, asynchronous active-low reset
//   host_valid/host_ready        command handshake
//   host_wr/host_addr/host_len   command fields (len 0 = null command)
//   sdram_init_done              controller ready
//   sdram_wr_ack/sdram_rd_ack    controller acks (level, multi-cycle)
//   sdram_wr_req/sdram_rd_req    registered requests
//   sdwr_bytes/sdrd_bytes        burst length of the current command
//   sys_addr                     address of the current command
//   done/done_wr                 completion pulse and its direction
//   err_timeout                  sticky abort flag
//   busy                         queue non-empty or transaction in flight
// ---------------------------------------------------------------------------
module sdram_req_master
    import sdram_req_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk_100m,
    input  logic              rst_n,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [LEN_W-1:0]  host_len,
    input  logic              sdram_init_done,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [LEN_W-1:0]  sdwr_bytes,
    output logic [LEN_W-1:0]  sdrd_bytes,
    output logic [ADDR_W-1:0] sys_addr,
    output logic              done,
    output logic              done_wr,
    output logic              err_timeout,
    output logic              busy
`ifdef SDRAM_REQ_STATS_EN
    ,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_to_cnt
`endif
);

    localparam int unsigned ENTRY_W = entry_w(ADDR_W);
    localparam int unsigned WR_BIT  = wr_bit(ADDR_W);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    // FIFO interface
    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    logic               head_wr;
    logic [ADDR_W-1:0]  head_addr;
    logic [LEN_W-1:0]   head_len;

    state_e state_q, state_d;

    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] sys_addr_q, sys_addr_d;
    logic [LEN_W-1:0]  wr_bytes_q, wr_bytes_d;
    logic [LEN_W-1:0]  rd_bytes_q, rd_bytes_d;
    logic              done_q, done_d;
    logic              done_wr_q, done_wr_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              ack_low_q, ack_low_d;     // ack seen low since request rose
    logic              timed_out_q, timed_out_d; // current command was aborted

`ifdef SDRAM_REQ_STATS_EN
    logic [15:0] stat_rd_q, stat_rd_d;
    logic [15:0] stat_wr_q, stat_wr_d;
    logic [15:0] stat_to_q, stat_to_d;
`endif

    logic match_ack;
    logic to_hit;
    logic ack_take;

    sdram_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .wdata    (fifo_wdata),
        .pop      (fifo_pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign fifo_wdata = {host_wr, host_addr, host_len};
    assign host_ready = !fifo_full || fifo_pop;
    assign fifo_push  = host_valid && host_ready;

    assign head_wr   = fifo_rdata[WR_BIT];
    assign head_addr = fifo_rdata[ADDR_LSB +: ADDR_W];
    assign head_len  = fifo_rdata[LEN_LSB +: LEN_W];

    // Only the ack matching the latched direction matters; the other one
    // belongs to refresh or another master.
    assign match_ack = dir_q ? sdram_wr_ack : sdram_rd_ack;
    assign to_hit    = ((state_q == S_REQ) || (state_q == S_ACK)) && (to_cnt_q == TO_LAST);
    // A stale high ack from a previous burst is not accepted until it has
    // been sampled low at least once during this request.
    assign ack_take  = (state_q == S_REQ) && match_ack && ack_low_q;

    // State register
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT_INIT: begin
                if (sdram_init_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!sdram_init_done) begin
                    state_d = S_WAIT_INIT;
                end else if (!fifo_empty && (head_len != '0)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (to_hit || ack_take) begin
                    state_d = to_hit ? S_DONE : S_ACK;
                end
            end
            S_ACK: begin
                if (to_hit || !match_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_WAIT_INIT;
            end
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        wr_req_d    = wr_req_q;
        rd_req_d    = rd_req_q;
        dir_d       = dir_q;
        sys_addr_d  = sys_addr_q;
        wr_bytes_d  = wr_bytes_q;
        rd_bytes_d  = rd_bytes_q;
        done_d      = 1'b0;
        done_wr_d   = 1'b0;
        err_d       = err_q;
        to_cnt_d    = to_cnt_q;
        ack_low_d   = ack_low_q;
        timed_out_d = timed_out_q;
        fifo_pop    = 1'b0;
`ifdef SDRAM_REQ_STATS_EN
        stat_rd_d   = stat_rd_q;
        stat_wr_d   = stat_wr_q;
        stat_to_d   = stat_to_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (sdram_init_done && !fifo_empty) begin
                    sys_addr_d = head_addr;
                    dir_d      = head_wr;
                    wr_bytes_d = head_wr ? head_len : '0;
                    rd_bytes_d = head_wr ? '0 : head_len;
                    if (head_len == '0) begin
                        // Null command: retire without touching the controller.
                        fifo_pop  = 1'b1;
                        done_d    = 1'b1;
                        done_wr_d = head_wr;
                    end else begin
                        wr_req_d    = head_wr;
                        rd_req_d    = !head_wr;
                        to_cnt_d    = '0;
                        ack_low_d   = 1'b0;
                        timed_out_d = 1'b0;
                    end
                end
            end
            S_REQ: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (!match_ack) begin
                    ack_low_d = 1'b1;
                end
                if (to_hit) begin
                    wr_req_d    = 1'b0;
                    rd_req_d    = 1'b0;
                    err_d       = 1'b1;
                    timed_out_d = 1'b1;
                end else if (ack_take) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                end
            end
            S_ACK: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (to_hit) begin
                    err_d       = 1'b1;
                    timed_out_d = 1'b1;
                end
            end
            S_DONE: begin
                done_d     = 1'b1;
                done_wr_d  = dir_q;
                fifo_pop   = 1'b1;
                sys_addr_d = '0;
                wr_bytes_d = '0;
                rd_bytes_d = '0;
`ifdef SDRAM_REQ_STATS_EN
                if (timed_out_q) begin
                    if (stat_to_q != 16'hFFFF) stat_to_d = stat_to_q + 16'd1;
                end else if (dir_q) begin
                    if (stat_wr_q != 16'hFFFF) stat_wr_d = stat_wr_q + 16'd1;
                end else begin
                    if (stat_rd_q != 16'hFFFF) stat_rd_d = stat_rd_q + 16'd1;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    // Datapath / output registers
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            dir_q       <= 1'b0;
            sys_addr_q  <= '0;
            wr_bytes_q  <= '0;
            rd_bytes_q  <= '0;
            done_q      <= 1'b0;
            done_wr_q   <= 1'b0;
            err_q       <= 1'b0;
            to_cnt_q    <= '0;
            ack_low_q   <= 1'b0;
            timed_out_q <= 1'b0;
`ifdef SDRAM_REQ_STATS_EN
            stat_rd_q   <= '0;
            stat_wr_q   <= '0;
            stat_to_q   <= '0;
`endif
        end else begin
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            dir_q       <= dir_d;
            sys_addr_q  <= sys_addr_d;
            wr_bytes_q  <= wr_bytes_d;
            rd_bytes_q  <= rd_bytes_d;
            done_q      <= done_d;
            done_wr_q   <= done_wr_d;
            err_q       <= err_d;
            to_cnt_q    <= to_cnt_d;
            ack_low_q   <= ack_low_d;
            timed_out_q <= timed_out_d;
`ifdef SDRAM_REQ_STATS_EN
            stat_rd_q   <= stat_rd_d;
            stat_wr_q   <= stat_wr_d;
            stat_to_q   <= stat_to_d;
`endif
        end
    end

    assign sdram_wr_req = wr_req_q;
    assign sdram_rd_req = rd_req_q;
    assign sdwr_bytes   = wr_bytes_q;
    assign sdrd_bytes   = rd_bytes_q;
    assign sys_addr     = sys_addr_q;
    assign done         = done_q;
    assign done_wr      = done_wr_q;
    assign err_timeout  = err_q;
    assign busy         = (fifo_count != '0) ||
                          (state_q == S_REQ) || (state_q == S_ACK) || (state_q == S_DONE);

`ifdef SDRAM_REQ_STATS_EN
    assign stat_rd_cnt = stat_rd_q;
    assign stat_wr_cnt = stat_wr_q;
    assign stat_to_cnt = stat_to_q;
`endif

endmodule

// File: tb/tb_sdram_req_master.sv
// ---------------------------------------------------------------------------
// tb_sdram_req_master
// Directed bench for sdram_req_master (ADDR_W=22, FIFO_DEPTH=4,
// TIMEOUT_CYC=64). The bench plays the controller side by driving the acks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_req_master;

    logic        clk_100m = 1'b0;
    logic        rst_n;
    logic        host_valid;
    logic        host_ready;
    logic        host_wr;
    logic [21:0] host_addr;
    logic [7:0]  host_len;
    logic        sdram_init_done;
    logic        sdram_wr_ack;
    logic        sdram_rd_ack;
    logic        sdram_wr_req;
    logic        sdram_rd_req;
    logic [7:0]  sdwr_bytes;
    logic [7:0]  sdrd_bytes;
    logic [21:0] sys_addr;
    logic        done;
    logic        done_wr;
    logic        err_timeout;
    logic        busy;
`ifdef SDRAM_REQ_STATS_EN
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_to_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_100m = ~clk_100m;

    sdram_req_master #(
        .ADDR_W      (22),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk_100m        (clk_100m),
        .rst_n           (rst_n),
        .host_valid      (host_valid),
        .host_ready      (host_ready),
        .host_wr         (host_wr),
        .host_addr       (host_addr),
        .host_len        (host_len),
        .sdram_init_done (sdram_init_done),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdwr_bytes      (sdwr_bytes),
        .sdrd_bytes      (sdrd_bytes),
        .sys_addr        (sys_addr),
        .done            (done),
        .done_wr         (done_wr),
        .err_timeout     (err_timeout),
        .busy            (busy)
`ifdef SDRAM_REQ_STATS_EN
        ,
        .stat_rd_cnt     (stat_rd_cnt),
        .stat_wr_cnt     (stat_wr_cnt),
        .stat_to_cnt     (stat_to_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic set_ack(input logic wr, input logic v);
        if (wr) sdram_wr_ack = v;
        else    sdram_rd_ack = v;
    endtask

    // Holds host_valid until accepted (or max_wait cycles pass).
    task automatic push_cmd(input logic wr, input logic [21:0] addr, input logic [7:0] len,
                            input int max_wait, output logic acc);
        int w;
        host_valid = 1'b1;
        host_wr    = wr;
        host_addr  = addr;
        host_len   = len;
        w = 0;
        while (!host_ready && w < max_wait) begin
            tick();
            w++;
        end
        acc = host_ready;
        tick();
        host_valid = 1'b0;
    endtask

    // Waits for the command to issue, checks it, plays a full ack burst and
    // checks the completion pulse. With stale=1 the ack is already high when
    // the request rises and must not be taken until it has been seen low.
    task automatic serve(input logic wr, input logic [21:0] addr, input logic [7:0] len,
                         input int delay, input int alen, input bit stale);
        int n;
        logic req;
        if (stale) set_ack(wr, 1'b1);
        n = 0;
        req = wr ? sdram_wr_req : sdram_rd_req;
        while (!req && n < 20) begin
            tick();
            n++;
            req = wr ? sdram_wr_req : sdram_rd_req;
        end
        check("issue", req, 1'b1);
        check("other_req_low", wr ? sdram_rd_req : sdram_wr_req, 1'b0);
        check("sys_addr", sys_addr, addr);
        check("bytes", wr ? sdwr_bytes : sdrd_bytes, len);
        check("unused_bytes", wr ? sdrd_bytes : sdwr_bytes, 8'd0);
        if (stale) begin
            repeat (3) tick();
            check("stale_ack_ignored", wr ? sdram_wr_req : sdram_rd_req, 1'b1);
            set_ack(wr, 1'b0);
        end
        repeat (delay) tick();
        check("req_hold", wr ? sdram_wr_req : sdram_rd_req, 1'b1);
        set_ack(wr, 1'b1);
        tick();
        check("req_drop", wr ? sdram_wr_req : sdram_rd_req, 1'b0);
        repeat (alen - 1) tick();
        check("addr_hold", sys_addr, addr);
        set_ack(wr, 1'b0);
        tick();
        check("done_early", done, 1'b0);
        tick();
        check("done", done, 1'b1);
        check("done_wr", done_wr, wr);
        check("addr_clear", sys_addr, 22'd0);
        tick();
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int   n;
        int   reqs;
        int   dcnt;
        logic dwr;
        logic acc;

        rst_n           = 1'b0;
        host_valid      = 1'b0;
        host_wr         = 1'b0;
        host_addr       = '0;
        host_len        = '0;
        sdram_init_done = 1'b0;
        sdram_wr_ack    = 1'b0;
        sdram_rd_ack    = 1'b0;
        #25;
        check("rst_host_ready", host_ready, 1'b1);
        check("rst_wr_req", sdram_wr_req, 1'b0);
        check("rst_rd_req", sdram_rd_req, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err_timeout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sys_addr", sys_addr, 22'd0);
        @(negedge clk_100m);
        rst_n = 1'b1;
        tick();

        // 1: nothing issues before init_done, then a write issues quickly.
        push_cmd(1'b1, 22'h000100, 8'd8, 4, acc);
        check("push_accept", acc, 1'b1);
        reqs = 0;
        repeat (49) begin
            if (sdram_wr_req || sdram_rd_req) reqs++;
            tick();
        end
        check("no_req_before_init", reqs, 0);
        check("busy_queued", busy, 1'b1);
        sdram_init_done = 1'b1;
        n = 0;
        while (!sdram_wr_req && n < 5) begin
            tick();
            n++;
        end
        check("init_to_req_le2", (n <= 2), 1'b1);
        serve(1'b1, 22'h000100, 8'd8, 2, 3, 1'b0);

        // 2: read, ack 5 cycles after request for 4 cycles.
        push_cmd(1'b0, 22'h00002A, 8'd4, 4, acc);
        serve(1'b0, 22'h00002A, 8'd4, 5, 4, 1'b0);

        // 3: five back-to-back commands into a depth-4 queue.
        fork
            begin
                push_cmd(1'b1, 22'h000A01, 8'd2, 4, acc);
                push_cmd(1'b0, 22'h000B02, 8'd3, 4, acc);
                push_cmd(1'b1, 22'h000C03, 8'd4, 4, acc);
                push_cmd(1'b0, 22'h000D04, 8'd5, 4, acc);
                check("full_ready_low", host_ready, 1'b0);
                push_cmd(1'b1, 22'h000E05, 8'd6, 200, acc);
                check("fifth_accepted", acc, 1'b1);
                check("fifth_with_pop", done, 1'b1);
                check("full_again", host_ready, 1'b0);
            end
            begin
                serve(1'b1, 22'h000A01, 8'd2, 2, 3, 1'b0);
                serve(1'b0, 22'h000B02, 8'd3, 1, 2, 1'b0);
                serve(1'b1, 22'h000C03, 8'd4, 3, 1, 1'b0);
                serve(1'b0, 22'h000D04, 8'd5, 2, 2, 1'b0);
                serve(1'b1, 22'h000E05, 8'd6, 2, 3, 1'b0);
            end
        join

        // 4: null command completes without a request.
        push_cmd(1'b1, 22'h000055, 8'd0, 4, acc);
        reqs = 0;
        dcnt = 0;
        dwr  = 1'b0;
        repeat (6) begin
            tick();
            if (done) begin
                dcnt++;
                dwr = done_wr;
            end
            if (sdram_wr_req || sdram_rd_req) reqs++;
        end
        check("null_done_count", dcnt, 1);
        check("null_done_wr", dwr, 1'b1);
        check("null_no_req", reqs, 0);
        check("null_idle", busy, 1'b0);

        // 5: read never acked (wr_ack noise ignored), then a queued write
        //    with a stale ack level.
        push_cmd(1'b0, 22'h000003, 8'd2, 4, acc);
        push_cmd(1'b1, 22'h000004, 8'd1, 4, acc);
        n = 0;
        while (!sdram_rd_req && n < 20) begin
            tick();
            n++;
        end
        sdram_wr_ack = 1'b1;
        n = 0;
        while (sdram_rd_req && n < 200) begin
            n++;
            tick();
            if (n == 10) sdram_wr_ack = 1'b0;
        end
        check("timeout_req_cycles", n, 64);
        check("timeout_err", err_timeout, 1'b1);
        check("timeout_done_early", done, 1'b0);
        tick();
        check("timeout_done", done, 1'b1);
        check("timeout_done_wr", done_wr, 1'b0);
        serve(1'b1, 22'h000004, 8'd1, 2, 2, 1'b1);
        check("err_sticky", err_timeout, 1'b1);

`ifdef SDRAM_REQ_STATS_EN
        check("stat_wr", stat_wr_cnt, 16'd5);
        check("stat_rd", stat_rd_cnt, 16'd3);
        check("stat_to", stat_to_cnt, 16'd1);
`endif

        // 6: reset asserted while in S_ACK.
        push_cmd(1'b1, 22'h000077, 8'd4, 4, acc);
        n = 0;
        while (!sdram_wr_req && n < 20) begin
            tick();
            n++;
        end
        tick();
        sdram_wr_ack = 1'b1;
        tick();
        check("pre_rst_in_ack", sdram_wr_req, 1'b0);
        check("pre_rst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_done", done, 1'b0);
        check("arst_err", err_timeout, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_host_ready", host_ready, 1'b1);
        check("arst_sys_addr", sys_addr, 22'd0);
        check("arst_bytes", sdwr_bytes, 8'd0);
        sdram_wr_ack = 1'b0;
        @(negedge clk_100m);
        rst_n = 1'b1;
        dcnt = 0;
        reqs = 0;
        repeat (10) begin
            tick();
            if (done) dcnt++;
            if (sdram_wr_req || sdram_rd_req) reqs++;
        end
        check("post_rst_no_done", dcnt, 0);
        check("post_rst_no_req", reqs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
